rr_grant_scheduler: RTL

- Round-robin scheduler that shares one resource among NUM_REQ requesters.
- Registers a winner index and drives a one-hot grant vector, decoded from that index and gated by grant-valid.
- Holds each grant until the owner signals completion, then rotates priority.
- Sits in front of shared buses and memories; its grant vector drives per-requester select lines.

---
 rtl/rr_grant_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin owner selection for one shared resource.
// A winner index is registered on arbitration; the one-hot grant is decoded
// from that index and held until the owner pulses done_i.
// Optional forced release after MAX_HOLD busy cycles:
//    `define RR_GRANT_SCHEDULER_TIMEOUT_EN
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate among req_i starting at ptr_q
// BUSY  | owner gnt_idx_o holds the resource until done_i (or timeout)
module rr_grant_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       done_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       gnt_valid_o,
    output logic                       timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || MAX_HOLD < 1) begin : g_param_check
        $error("rr_grant_scheduler: NUM_REQ must be >= 2 and MAX_HOLD >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_hit;
    logic             force_rel;

`ifdef RR_GRANT_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Hold counter register; sits at zero while idle so it starts clean in BUSY.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count busy cycles; a coincident done_i takes precedence over the timeout.
    always_comb begin
        cnt_d     = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
        force_rel = (state_q == BUSY) && !done_i && (cnt_q == CNT_LAST);
    end
`else
    assign force_rel = 1'b0;
`endif

    // Rotating search: first requester at or after ptr_q, wrapping by compare.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        pick_idx = '0;
        pick_hit = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!pick_hit && req_i[cand]) begin
                pick_idx = cand;
                pick_hit = 1'b1;
            end
        end
    end

    // State, priority pointer and owner index registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: arbitrate in IDLE, hold in BUSY until done or forced release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    idx_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done_i || force_rel) begin
                    ptr_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant decoded from the registered index, gated by BUSY.
    always_comb begin
        gnt_valid_o = (state_q == BUSY);
        gnt_idx_o   = idx_q;
        gnt_o       = '0;
        if (gnt_valid_o) begin
            gnt_o[idx_q] = 1'b1;
        end
        timeout_o   = force_rel;
    end

endmodule
